dac_seg_v1p5: RTL and testbench



---
 rtl/dac_seg_v1p5.sv | 117 +++++++++++
 tb/tb_dac_seg_v1p5.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/dac_seg_v1p5.sv
// dac_seg_v1p5: saturate, mute-ramp and segment a signed code into weight-4 (VB) and unit (VC) counts.
// Define SEG_DITHER_EN to add LFSR dither on the VC == -2 split.
module dac_seg_v1p5 #(
    parameter int          RAMP_STEP = 1,
    parameter logic [15:0] SEED      = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_en,
    input  logic              mute,
    input  logic signed [7:0] din,
    output logic signed [5:0] VB,
    output logic signed [3:0] VC,
    output logic              sat_flag,
    output logic [15:0]       sat_cnt,
    output logic              muted
);
    typedef enum logic [1:0] {S_MUTED, S_UP, S_RUN, S_DOWN} state_t;
    state_t            state_q, state_d;
    logic [6:0]        lim_q, lim_d, lim_up, lim_dn;
    logic [7:0]        up_sum;
    logic signed [7:0] s, y, lim_s, y1_q, q, vb_c, vc_c, vb_f, vc_f;
    logic              clip, clip1_q, dith;

    if (RAMP_STEP < 1 || RAMP_STEP > 78) begin : g_bad_step
        $error("RAMP_STEP must be within 1..78");
    end
    if (SEED == 16'h0) begin : g_bad_seed
        $error("SEED must be non-zero");
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_MUTED;
            lim_q   <= '0;
        end else if (clk_en) begin
            state_q <= state_d;
            lim_q   <= lim_d;
        end
    end

    // A mute change mid-ramp reverses direction without moving the limit that cycle.
    always_comb begin
        up_sum  = {1'b0, lim_q} + 8'(RAMP_STEP);
        lim_up  = (up_sum >= 8'd78) ? 7'd78 : up_sum[6:0];
        lim_dn  = (lim_q <= 7'(RAMP_STEP)) ? 7'd0 : lim_q - 7'(RAMP_STEP);
        state_d = state_q;
        lim_d   = lim_q;
        case (state_q)
            S_MUTED: state_d = mute ? S_MUTED : S_UP;
            S_UP: begin
                lim_d   = mute ? lim_q : lim_up;
                state_d = mute ? S_DOWN : ((lim_up == 7'd78) ? S_RUN : S_UP);
            end
            S_RUN: state_d = mute ? S_DOWN : S_RUN;
            default: begin
                lim_d   = mute ? lim_dn : lim_q;
                state_d = !mute ? S_UP : ((lim_dn == 7'd0) ? S_MUTED : S_DOWN);
            end
        endcase
    end

    always_comb muted = (state_q == S_MUTED);

    always_comb begin
        lim_s = signed'({1'b0, lim_q});
        s     = (din > 8'sd78) ? 8'sd78 : (din < -8'sd78) ? -8'sd78 : din;
        y     = (s > lim_s) ? lim_s : (s < -lim_s) ? -lim_s : s;
        clip  = (s != din) || (y != s);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y1_q    <= '0;
            clip1_q <= 1'b0;
        end else if (clk_en) begin
            y1_q    <= y;
            clip1_q <= clip;
        end
    end

    always_comb begin
        q    = (y1_q + 8'sd2) >>> 2;
        vb_c = (q > 8'sd18) ? 8'sd18 : (q < -8'sd18) ? -8'sd18 : q;
        vc_c = y1_q - (vb_c <<< 2);
    end

`ifdef SEG_DITHER_EN
    logic [15:0] lfsr_q;
    always_ff @(posedge clk) begin
        if (rst) lfsr_q <= SEED;
        else if (clk_en) lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    end
    assign dith = lfsr_q[0] && (vc_c == -8'sd2) && (vb_c > -8'sd18);
`else
    assign dith = 1'b0;
`endif

    always_comb begin
        vb_f = dith ? vb_c - 8'sd1 : vb_c;
        vc_f = dith ? vc_c + 8'sd4 : vc_c;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            VB       <= '0;
            VC       <= '0;
            sat_flag <= 1'b0;
            sat_cnt  <= '0;
        end else if (clk_en) begin
            VB       <= 6'(vb_f);
            VC       <= 4'(vc_f);
            sat_flag <= clip1_q;
            if (clip1_q && sat_cnt != 16'hFFFF) sat_cnt <= sat_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_dac_seg_v1p5.sv
// tb_dac_seg_v1p5: vector table, hand sequences and randomized run against an arithmetic model.
module tb_dac_seg_v1p5;
    localparam int STEP = 1;
    logic              clk = 1'b0, rst = 1'b1, clk_en = 1'b1, mute = 1'b0;
    logic signed [7:0] din = '0;
    logic signed [5:0] VB;
    logic signed [3:0] VC;
    logic              sat_flag, muted;
    logic [15:0]       sat_cnt;

    dac_seg_v1p5 #(.RAMP_STEP(STEP), .SEED(16'hACE1)) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en), .mute(mute), .din(din),
        .VB(VB), .VC(VC), .sat_flag(sat_flag), .sat_cnt(sat_cnt), .muted(muted)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0;
    int m_ph, m_lim, m_y1, m_c1, m_vb, m_vc, m_fl, m_cnt;

    typedef struct { int d; int vb; int vc; int fl; } vec_t;
    vec_t vecs[12];

    function automatic void check(string nm, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endfunction

    function automatic int clampi(int v, int m);
        return (v > m) ? m : (v < -m) ? -m : v;
    endfunction

    // Reference split: floor division written out explicitly, then clamp.
    function automatic void split(int yv, output int vb, output int vc);
        int t = yv + 2;
        vb = (t >= 0) ? t / 4 : -((-t + 3) / 4);
        vb = clampi(vb, 18);
        vc = yv - 4 * vb;
    endfunction

    // ph: 0 muted, 1 ramping up, 2 full scale, 3 ramping down
    function automatic void model_step();
        int dv, sv, yv;
        if (rst) begin
            m_ph = 0; m_lim = 0; m_y1 = 0; m_c1 = 0;
            m_vb = 0; m_vc = 0; m_fl = 0; m_cnt = 0;
        end else if (clk_en) begin
            split(m_y1, m_vb, m_vc);
            m_fl = m_c1;
            if (m_c1 != 0 && m_cnt < 65535) m_cnt++;
            dv = din;
            sv = clampi(dv, 78);
            yv = clampi(sv, m_lim);
            m_c1 = (sv != dv || yv != sv) ? 1 : 0;
            m_y1 = yv;
            case (m_ph)
                0: if (!mute) m_ph = 1;
                1: if (mute) m_ph = 3;
                   else begin
                       m_lim = (m_lim + STEP > 78) ? 78 : m_lim + STEP;
                       if (m_lim == 78) m_ph = 2;
                   end
                2: if (mute) m_ph = 3;
                default: if (!mute) m_ph = 1;
                   else begin
                       m_lim = (m_lim - STEP < 0) ? 0 : m_lim - STEP;
                       if (m_lim == 0) m_ph = 0;
                   end
            endcase
        end
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check("vb", VB, m_vb);
        check("vc", VC, m_vc);
        check("sat_flag", sat_flag, m_fl);
        check("sat_cnt", sat_cnt, m_cnt);
        check("muted", muted, (m_ph == 0) ? 1 : 0);
    endtask

    task automatic run_until_full();
        mute = 1'b0;
        for (int n = 0; n < 300 && m_ph != 2; n++) tick();
        if (m_ph != 2) begin
            tests++; fails++;
            $display("FAIL ramp_up_timeout: got phase %0d expected 2", m_ph);
        end
    endtask

    initial begin
        int c0, prev_y, y_now;
        vecs[0]  = '{6, 2, -2, 0};
        vecs[1]  = '{5, 1, 1, 0};
        vecs[2]  = '{-78, -18, -6, 0};
        vecs[3]  = '{100, 18, 6, 1};
        vecs[4]  = '{-128, -18, -6, 1};
        vecs[5]  = '{-1, 0, -1, 0};
        vecs[6]  = '{-3, -1, 1, 0};
        vecs[7]  = '{2, 1, -2, 0};
        vecs[8]  = '{77, 18, 5, 0};
        vecs[9]  = '{-6, -1, -2, 0};
        vecs[10] = '{78, 18, 6, 0};
        vecs[11] = '{0, 0, 0, 0};

        rst = 1'b1; mute = 1'b0; din = 8'sd78;
        tick(); tick();
        check("rst_vb", VB, 0);
        check("rst_vc", VC, 0);
        check("rst_cnt", sat_cnt, 0);
        check("rst_muted", muted, 1);

        rst = 1'b0;
        tick();
        check("muted_fall", muted, 0);
        repeat (80) tick();
        check("ramp_end_vb", VB, 18);
        check("ramp_end_vc", VC, 6);
        check("ramp_end_cnt", sat_cnt, 79);

        foreach (vecs[i]) begin
            din = 8'(vecs[i].d);
            tick(); tick();
            check("vec_vb", VB, vecs[i].vb);
            check("vec_vc", VC, vecs[i].vc);
            check("vec_flag", sat_flag, vecs[i].fl);
        end

        c0 = m_cnt;
        din = 8'sd100;  tick();
        din = -8'sd128; tick();
        check("sat_pair_vb0", VB, 18);
        check("sat_pair_vc0", VC, 6);
        check("sat_pair_fl0", sat_flag, 1);
        din = 8'sd0; tick();
        check("sat_pair_vb1", VB, -18);
        check("sat_pair_vc1", VC, -6);
        check("sat_pair_fl1", sat_flag, 1);
        check("sat_pair_cnt", sat_cnt, c0 + 2);

        for (int d = -78; d <= 78; d++) begin
            din = 8'(d);
            tick();
            if (d > -78) check("sweep_sum", 4 * VB + VC, d - 1);
        end

        din = 8'sd78; tick(); tick();
        prev_y = 4 * VB + VC;
        mute = 1'b1;
        for (int n = 0; n < 200 && m_lim != 40; n++) begin
            tick();
            y_now = 4 * VB + VC;
            check("down_step", (y_now - prev_y <= 1 && prev_y - y_now <= 1) ? 1 : 0, 1);
            check("down_muted", muted, 0);
            prev_y = y_now;
        end
        if (m_lim != 40) begin
            tests++; fails++;
            $display("FAIL ramp_down_timeout: got limit %0d expected 40", m_lim);
        end
        mute = 1'b0;
        for (int n = 0; n < 200 && m_ph != 2; n++) begin
            tick();
            y_now = 4 * VB + VC;
            check("up_step", (y_now - prev_y <= 1 && prev_y - y_now <= 1) ? 1 : 0, 1);
            check("up_muted", muted, 0);
            prev_y = y_now;
        end
        tick(); tick();
        check("rerun_vb", VB, 18);
        check("rerun_vc", VC, 6);

        for (int n = 0; n < 500; n++) begin
            clk_en = 1'($urandom % 2);
            din = 8'($urandom_range(0, 255));
            if ($urandom % 24 == 0) mute = ~mute;
            tick();
        end
        clk_en = 1'b1;

        run_until_full();
        mute = 1'b1; din = 8'sd50;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        check("rst_dn_vb", VB, 0);
        check("rst_dn_vc", VC, 0);
        check("rst_dn_cnt", sat_cnt, 0);
        check("rst_dn_muted", muted, 1);
        rst = 1'b0;
        tick(); tick();
        check("post_rst_vb", VB, 0);
        check("post_rst_vc", VC, 0);
        check("post_rst_flag", sat_flag, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
